// File: rtl/axis_pkg.sv
// Shared types and round-robin helpers for the AXI-Stream packet arbiter.
package axis_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Index wrap for a scan offset that can exceed n-1 by at most n-1.
   function automatic int rr_wrap(input int idx, input int n);
      return (idx >= n) ? idx - n : idx;
   endfunction

   // Successor in round-robin order; explicit compare keeps non-power-of-2 n exact.
   function automatic int rr_next(input int idx, input int n);
      return (idx == n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/axis_register.sv
// One-deep AXI-Stream register slice carrying tlast, tdata and a user sideband.
module axis_register #(
   parameter int DATA_W = 8,
   parameter int USER_W = 1
) (
   input  logic              clk,
   input  logic              sresetn,
   input  logic              i_s_tvalid,
   output logic              o_s_tready,
   input  logic              i_s_tlast,
   input  logic [DATA_W-1:0] i_s_tdata,
   input  logic [USER_W-1:0] i_s_tuser,
   output logic              o_m_tvalid,
   input  logic              i_m_tready,
   output logic              o_m_tlast,
   output logic [DATA_W-1:0] o_m_tdata,
   output logic [USER_W-1:0] o_m_tuser
);

   logic              r_valid;
   logic              r_last;
   logic [DATA_W-1:0] r_data;
   logic [USER_W-1:0] r_user;
   logic              w_load;

   // Accept whenever the slot is empty or is being drained this cycle.
   assign o_s_tready = !r_valid || i_m_tready;
   assign w_load     = i_s_tvalid && o_s_tready;

   always_ff @(posedge clk) begin
      if (!sresetn) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_data  <= '0;
         r_user  <= '0;
      end else if (w_load) begin
         r_valid <= 1'b1;
         r_last  <= i_s_tlast;
         r_data  <= i_s_tdata;
         r_user  <= i_s_tuser;
      end else if (i_m_tready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_m_tvalid = r_valid;
   assign o_m_tlast  = r_last;
   assign o_m_tdata  = r_data;
   assign o_m_tuser  = r_user;

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-atomic round-robin merge of several AXI-Stream inputs onto one registered
// output; axis_o_tsrc tags each beat with the input it came from.
module axis_packet_arbiter
   import axis_pkg::*;
#(
   parameter int AXIS_BYTES         = 1,
   parameter int NUM_MASTER_STREAMS = 2,
   localparam int SRC_BITS = (NUM_MASTER_STREAMS > 1) ? $clog2(NUM_MASTER_STREAMS) : 1,
   localparam int DATA_W   = AXIS_BYTES * 8
) (
   input  logic                                 clk,
   input  logic                                 sresetn,
   output logic [NUM_MASTER_STREAMS-1:0]        axis_i_tready,
   input  logic [NUM_MASTER_STREAMS-1:0]        axis_i_tvalid,
   input  logic [NUM_MASTER_STREAMS-1:0]        axis_i_tlast,
   input  logic [NUM_MASTER_STREAMS*DATA_W-1:0] axis_i_tdata,
   input  logic                                 axis_o_tready,
   output logic                                 axis_o_tvalid,
   output logic                                 axis_o_tlast,
   output logic [DATA_W-1:0]                    axis_o_tdata,
   output logic [SRC_BITS-1:0]                  axis_o_tsrc
);

   localparam int N = NUM_MASTER_STREAMS;

   arb_state_t          r_state;
   arb_state_t          w_state_next;
   logic [SRC_BITS-1:0] r_grant;
   logic [SRC_BITS-1:0] w_grant_next;
   logic [SRC_BITS-1:0] r_rr_ptr;
   logic [SRC_BITS-1:0] w_rr_ptr_next;

   logic [N-1:0]        w_rot_valid;
   logic                w_found;
   logic [SRC_BITS-1:0] w_pick;

   logic                w_gvalid;
   logic                w_glast;
   logic [DATA_W-1:0]   w_gdata;
   logic                w_accept;
   logic                w_handshake;
   logic                w_load_valid;

   // Rotate valids so position 0 is the round-robin pointer, then take the lowest set bit.
   always_comb begin
      w_rot_valid = '0;
      w_found     = 1'b0;
      w_pick      = '0;
      for (int k = 0; k < N; k++) begin
         for (int j = 0; j < N; j++) begin
            if (j == rr_wrap(int'(r_rr_ptr) + k, N)) begin
               w_rot_valid[k] = axis_i_tvalid[j];
            end
         end
      end
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot_valid[k]) begin
            w_found = 1'b1;
            w_pick  = SRC_BITS'(rr_wrap(int'(r_rr_ptr) + k, N));
         end
      end
   end

   always_comb begin
      w_gvalid = 1'b0;
      w_glast  = 1'b0;
      w_gdata  = '0;
      for (int i = 0; i < N; i++) begin
         if (SRC_BITS'(i) == r_grant) begin
            w_gvalid = axis_i_tvalid[i];
            w_glast  = axis_i_tlast[i];
            w_gdata  = axis_i_tdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign w_load_valid = (r_state == LOCKED) && w_gvalid;
   assign w_handshake  = w_load_valid && w_accept;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_tready
         assign axis_i_tready[gi] = sresetn && (r_state == LOCKED) &&
                                    (r_grant == SRC_BITS'(gi)) && w_accept;
      end
   endgenerate

   always_comb begin
      w_state_next  = r_state;
      w_grant_next  = r_grant;
      w_rr_ptr_next = r_rr_ptr;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_grant_next = w_pick;
               w_state_next = LOCKED;
            end
         end
         LOCKED: begin
            if (w_handshake && w_glast) begin
               w_state_next  = IDLE;
               w_rr_ptr_next = SRC_BITS'(rr_next(int'(r_grant), N));
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!sresetn) begin
         r_state  <= IDLE;
         r_grant  <= '0;
         r_rr_ptr <= '0;
      end else begin
         r_state  <= w_state_next;
         r_grant  <= w_grant_next;
         r_rr_ptr <= w_rr_ptr_next;
      end
   end

   axis_register #(
      .DATA_W (DATA_W),
      .USER_W (SRC_BITS)
   ) u_out_reg (
      .clk        (clk),
      .sresetn    (sresetn),
      .i_s_tvalid (w_load_valid),
      .o_s_tready (w_accept),
      .i_s_tlast  (w_glast),
      .i_s_tdata  (w_gdata),
      .i_s_tuser  (r_grant),
      .o_m_tvalid (axis_o_tvalid),
      .i_m_tready (axis_o_tready),
      .o_m_tlast  (axis_o_tlast),
      .o_m_tdata  (axis_o_tdata),
      .o_m_tuser  (axis_o_tsrc)
   );

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter with three inputs: per-source packet queues act as the
// reference; output beats are checked for order, atomicity, latency and stall stability.
module tb_axis_packet_arbiter;

   localparam int N = 3;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           sresetn;
   logic [N-1:0]   i_tready;
   logic [N-1:0]   i_tvalid;
   logic [N-1:0]   i_tlast;
   logic [N*W-1:0] i_tdata;
   logic           o_tready;
   logic           o_tvalid;
   logic           o_tlast;
   logic [W-1:0]   o_tdata;
   logic [1:0]     o_tsrc;

   always #5 clk = ~clk;

   axis_packet_arbiter #(
      .AXIS_BYTES         (1),
      .NUM_MASTER_STREAMS (N)
   ) dut (
      .clk           (clk),
      .sresetn       (sresetn),
      .axis_i_tready (i_tready),
      .axis_i_tvalid (i_tvalid),
      .axis_i_tlast  (i_tlast),
      .axis_i_tdata  (i_tdata),
      .axis_o_tready (o_tready),
      .axis_o_tvalid (o_tvalid),
      .axis_o_tlast  (o_tlast),
      .axis_o_tdata  (o_tdata),
      .axis_o_tsrc   (o_tsrc)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
      end
   endtask

   // {tlast, tdata} beats still to be offered, and beats the output still owes, per source
   logic [8:0] src_q [N][$];
   logic [8:0] exp_q [N][$];
   int         vld_pct = 100;
   int         rdy_pct = 100;
   bit         rdy_toggle = 1'b0;
   int         pause [N];
   int         gap_cnt [N];
   bit         in_pkt [N];
   int         cyc = 0;
   bit         sb_en = 1'b0;
   int         cur_src = -1;
   bit         stall_prev = 1'b0;
   logic [10:0] stall_val;
   bit         pend = 1'b0;
   logic [10:0] pend_val;
   int         log_src [$];
   int         log_last [$];
   int         log_cyc [$];
   int         log_data [$];

   task automatic add_pkt(input int s, input int len, input int base);
      logic [8:0] b;
      for (int k = 0; k < len; k++) begin
         b[7:0] = (base < 0) ? 8'($urandom) : 8'(base + k);
         b[8]   = (k == len - 1);
         src_q[s].push_back(b);
         exp_q[s].push_back(b);
      end
   endtask

   task automatic clear_log();
      log_src.delete();
      log_last.delete();
      log_cyc.delete();
      log_data.delete();
   endtask

   function automatic bit all_empty();
      bit e = 1'b1;
      for (int s = 0; s < N; s++) if (exp_q[s].size() != 0) e = 1'b0;
      return e;
   endfunction

   task automatic monitor();
      int         s;
      logic [8:0] e;
      logic [N-1:0] one = 1;
      chk("one_tready", 32'($countones(i_tready) <= 1), 1);
      for (int j = 0; j < N; j++) begin
         if (in_pkt[j]) chk("lock_others", 32'(i_tready & ~(one << j)), 0);
      end
      if (pend) begin
         chk("lat_valid", 32'(o_tvalid), 1);
         chk("lat_beat", 32'({o_tsrc, o_tlast, o_tdata}), 32'(pend_val));
      end
      if (stall_prev) begin
         chk("stall_valid", 32'(o_tvalid), 1);
         chk("stall_hold", 32'({o_tsrc, o_tlast, o_tdata}), 32'(stall_val));
      end
      stall_prev = o_tvalid && !o_tready;
      stall_val  = {o_tsrc, o_tlast, o_tdata};
      if (o_tvalid && o_tready) begin
         s = int'(o_tsrc);
         chk("src_range", 32'(s < N), 1);
         if (s < N) begin
            if (cur_src >= 0) chk("atomic_src", 32'(s), 32'(cur_src));
            chk("beat_owed", 32'(exp_q[s].size() > 0), 1);
            if (exp_q[s].size() > 0) begin
               e = exp_q[s].pop_front();
               chk("beat", 32'({o_tlast, o_tdata}), 32'(e));
            end
         end
         cur_src = o_tlast ? -1 : s;
         log_src.push_back(s);
         log_last.push_back(int'(o_tlast));
         log_cyc.push_back(cyc);
         log_data.push_back(int'(o_tdata));
      end
   endtask

   task automatic drive(input logic [N-1:0] hs);
      logic [8:0] b;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            b = src_q[i][0];
            in_pkt[i] = !b[8];
            void'(src_q[i].pop_front());
            i_tvalid[i] = 1'b0;
            if (gap_cnt[i] > 0) begin
               gap_cnt[i]--;
               if (gap_cnt[i] == 0) pause[i] = 3;
            end
         end
         if (pause[i] > 0) pause[i]--;
         else if (!i_tvalid[i] && src_q[i].size() > 0 && int'($urandom_range(99)) < vld_pct)
            i_tvalid[i] = 1'b1;
         if (i_tvalid[i]) begin
            b = src_q[i][0];
            i_tdata[i*W +: W] = b[7:0];
            i_tlast[i]        = b[8];
         end else begin
            i_tdata[i*W +: W] = 8'($urandom);
            i_tlast[i]        = 1'($urandom);
         end
      end
      o_tready = rdy_toggle ? ~o_tready : (int'($urandom_range(99)) < rdy_pct);
   endtask

   task automatic step();
      logic [N-1:0] hs;
      logic [8:0]   b;
      @(negedge clk);
      hs = i_tvalid & i_tready;
      if (sb_en) monitor();
      pend = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (hs[i]) begin
            b = src_q[i][0];
            pend = 1'b1;
            pend_val = {2'(i), b};
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      drive(hs);
   endtask

   task automatic drain(input string tag, input int cap);
      int n = 0;
      while (!all_empty() && n < cap) begin
         step();
         n++;
      end
      chk(tag, 32'(all_empty()), 1);
      repeat (3) step();
   endtask

   int rr_exp [8] = '{0, 0, 1, 1, 2, 2, 0, 0};
   int b_exp  [6] = '{1, 1, 1, 1, 0, 0};
   int d_exp  [8] = '{0, 0, 0, 0, 1, 1, 2, 2};

   initial begin
      int n;
      sresetn  = 1'b0;
      i_tvalid = '1;
      i_tlast  = '1;
      i_tdata  = '1;
      o_tready = 1'b1;
      for (int i = 0; i < N; i++) begin
         pause[i]   = 0;
         gap_cnt[i] = 0;
         in_pkt[i]  = 1'b0;
      end

      // Reset held with every input valid
      repeat (3) @(negedge clk);
      chk("rst_tready", 32'(i_tready), 0);
      chk("rst_ovalid", 32'(o_tvalid), 0);
      chk("rst_olast", 32'(o_tlast), 0);
      chk("rst_odata", 32'(o_tdata), 0);
      chk("rst_osrc", 32'(o_tsrc), 0);

      // Fairness: all inputs continuously valid with 2-beat packets
      for (int s = 0; s < N; s++) begin
         add_pkt(s, 2, 16 * s);
         add_pkt(s, 2, 16 * s + 8);
      end
      @(posedge clk);
      #1;
      sresetn  = 1'b1;
      i_tvalid = '0;
      drive('0);
      sb_en = 1'b1;
      clear_log();
      drain("rr_drain", 200);
      chk("rr_count", 32'(log_src.size()), 12);
      for (int k = 0; k < 8 && k < log_src.size(); k++) begin
         chk("rr_src", 32'(log_src[k]), 32'(rr_exp[k]));
         chk("rr_last", 32'(log_last[k]), 32'(k % 2));
      end
      if (log_cyc.size() >= 3) begin
         chk("rr_back2back", 32'(log_cyc[1] - log_cyc[0]), 1);
         chk("rr_pkt_gap", 32'(log_cyc[2] - log_cyc[1]), 2);
      end

      // Input 0 turns valid while input 1's packet is in flight
      clear_log();
      add_pkt(1, 4, 'hA0);
      repeat (3) step();
      add_pkt(0, 2, 'h50);
      drain("late_drain", 100);
      chk("late_count", 32'(log_src.size()), 6);
      for (int k = 0; k < 6 && k < log_src.size(); k++) begin
         chk("late_src", 32'(log_src[k]), 32'(b_exp[k]));
      end
      if (log_cyc.size() >= 4) chk("late_uninterrupted", 32'(log_cyc[3] - log_cyc[0]), 3);
      if (log_data.size() >= 4) chk("late_first", 32'(log_data[0]), 'hA0);

      // Output ready toggles every cycle
      clear_log();
      rdy_toggle = 1'b1;
      add_pkt(2, 4, -1);
      drain("bp_drain", 100);
      rdy_toggle = 1'b0;
      o_tready   = 1'b1;
      chk("bp_count", 32'(log_src.size()), 4);

      // Granted input pauses for 3 cycles after its second beat
      clear_log();
      add_pkt(0, 4, 'h10);
      add_pkt(1, 2, 'h20);
      add_pkt(2, 2, 'h30);
      gap_cnt[0] = 2;
      drain("gap_drain", 100);
      chk("gap_count", 32'(log_src.size()), 8);
      for (int k = 0; k < 8 && k < log_src.size(); k++) begin
         chk("gap_src", 32'(log_src[k]), 32'(d_exp[k]));
      end
      if (log_cyc.size() >= 3) chk("gap_len", 32'(log_cyc[2] - log_cyc[1]), 4);

      // Randomized traffic
      vld_pct = 60;
      rdy_pct = 70;
      for (int s = 0; s < N; s++) begin
         for (int p = 0; p < 8; p++) add_pkt(s, int'($urandom_range(4, 1)), -1);
      end
      drain("rand_drain", 3000);
      vld_pct = 100;
      rdy_pct = 100;

      // Reset during beat 2 of a 4-beat packet
      clear_log();
      add_pkt(1, 4, 'hC0);
      n = 0;
      while (log_src.size() < 2 && n < 30) begin
         step();
         n++;
      end
      chk("mid_reached", 32'(log_src.size() >= 2), 1);
      sresetn = 1'b0;
      sb_en   = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_ovalid", 32'(o_tvalid), 0);
      chk("mid_rst_tready", 32'(i_tready), 0);
      for (int s = 0; s < N; s++) begin
         src_q[s].delete();
         exp_q[s].delete();
         in_pkt[s] = 1'b0;
         pause[s]  = 0;
      end
      i_tvalid   = '0;
      cur_src    = -1;
      stall_prev = 1'b0;
      pend       = 1'b0;
      @(posedge clk);
      #1;
      sresetn = 1'b1;
      clear_log();
      add_pkt(2, 1, 'h72);
      add_pkt(1, 1, 'h71);
      add_pkt(0, 1, 'h70);
      drive('0);
      sb_en = 1'b1;
      drain("post_rst_drain", 100);
      chk("post_rst_count", 32'(log_src.size()), 3);
      if (log_src.size() >= 1) chk("post_rst_first", 32'(log_src[0]), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
